// File: rtl/ir_receiver_if.sv
// Processor-side control signals of the IR receiver (address, write strobe, interrupt pair).
interface ir_receiver_if;
  // Bus protocol: BUS_ADDR/BUS_WE are sampled on every rising clock edge.
  // A read (BUS_WE=0 at a decoded address) returns data on BUS_DATA during the following cycle only.
  // BUS_INTERRUPT_RAISE stays high until the cycle after BUS_INTERRUPT_ACK is seen high.
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic       BUS_INTERRUPT_RAISE;
  logic       BUS_INTERRUPT_ACK;

  modport master (
    output BUS_ADDR,
    output BUS_WE,
    output BUS_INTERRUPT_ACK,
    input  BUS_INTERRUPT_RAISE
  );

  modport slave (
    input  BUS_ADDR,
    input  BUS_WE,
    input  BUS_INTERRUPT_ACK,
    output BUS_INTERRUPT_RAISE
  );
endinterface

// File: rtl/ir_receiver.sv
// IR car-control packet decoder with bus-readable COMMAND/STATUS registers and interrupt.
// Optional macro IR_RX_REPEAT_CHECK_EN: accept a command only when two consecutive packets agree.
module ir_receiver #(
  parameter logic [7:0] IRRxBaseAddr    = 8'h94,
  parameter int         CARRIER_TIMEOUT = 4000,
  parameter int         GAP_TIMEOUT     = 200000,
  parameter int         START_PULSES    = 191,
  parameter int         SELECT_PULSES   = 47,
  parameter int         ONE_PULSES      = 47,
  parameter int         ZERO_PULSES     = 22,
  parameter int         TOL             = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         IR_IN,
  ir_receiver_if.slave bus,
  inout  wire  [7:0]   BUS_DATA,
  output logic [3:0]   COMMAND_OUT,
  output logic [2:0]   dbg_state_o,
  output logic         dbg_bus_oe_o
);
  localparam int CT_W = $clog2(CARRIER_TIMEOUT + 1);
  localparam int GT_W = $clog2(GAP_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BURST  = 3'd1,
    S_GAP    = 3'd2,
    S_ACCEPT = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  logic [1:0]      sync_q;
  logic            prev_q;
  logic            rise;
  logic            env_q, env_d;
  logic [CT_W-1:0] ct_q, ct_d;
  logic            env_fall;

  state_t          state_q, state_d;
  logic [8:0]      cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [GT_W-1:0] gap_q, gap_d;
  logic [3:0]      shift_q, shift_d;
  logic            burst_ok, burst_bit;
  logic            accept, error, commit;

  logic [3:0]      cmd_q, cmd_d;
  logic [2:0]      status_q, status_d;
  logic            raise_q, raise_d;
  logic            wr_clr, rd_hit;
  logic            rd_en_q;
  logic [7:0]      rd_data_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], IR_IN};
      prev_q <= sync_q[1];
    end
  end
  assign rise = sync_q[1] & ~prev_q;

  // Envelope stays high for CARRIER_TIMEOUT clocks after the most recent carrier edge.
  always_comb begin
    env_d = env_q;
    ct_d  = ct_q;
    if (rise) begin
      env_d = 1'b1;
      ct_d  = '0;
    end else if (env_q) begin
      if (ct_q == CT_W'(CARRIER_TIMEOUT - 1)) begin
        env_d = 1'b0;
        ct_d  = '0;
      end else begin
        ct_d = ct_q + 1'b1;
      end
    end
  end
  assign env_fall = env_q & ~env_d;

  function automatic logic in_win(input logic [8:0] c, input int nom);
    return (int'(c) >= nom - TOL) && (int'(c) <= nom + TOL);
  endfunction

  always_comb begin
    burst_bit = in_win(cnt_q, ONE_PULSES);
    burst_ok  = burst_bit | in_win(cnt_q, ZERO_PULSES);
    if (idx_q == 3'd0) burst_ok = in_win(cnt_q, START_PULSES);
    if (idx_q == 3'd1) burst_ok = in_win(cnt_q, SELECT_PULSES);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    shift_d = shift_q;
    accept  = 1'b0;
    error   = 1'b0;
    case (state_q)
      S_IDLE: begin
        idx_d   = '0;
        gap_d   = '0;
        shift_d = '0;
        cnt_d   = {8'd0, rise};
        // An envelope already high here is garbage that still gets judged as a start burst.
        if (rise || env_q) state_d = S_BURST;
      end
      S_BURST: begin
        if (rise && cnt_q != 9'h1FF) cnt_d = cnt_q + 9'd1;
        if (env_fall) begin
          gap_d = '0;
          if (!burst_ok) begin
            state_d = S_ERR;
          end else begin
            if (idx_q >= 3'd2) shift_d = {shift_q[2:0], burst_bit};
            state_d = (idx_q == 3'd5) ? S_ACCEPT : S_GAP;
          end
        end
      end
      S_GAP: begin
        if (rise) begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = 9'd1;
          state_d = S_BURST;
        end else if (gap_q == GT_W'(GAP_TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_ACCEPT: begin
        accept  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        error   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      env_q   <= 1'b0;
      ct_q    <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      shift_q <= '0;
    end else begin
      env_q   <= env_d;
      ct_q    <= ct_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
    end
  end

`ifdef IR_RX_REPEAT_CHECK_EN
  logic [3:0] cand_q;
  logic       cand_vld_q;

  assign commit = accept & cand_vld_q & (cand_q == shift_q);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cand_q     <= '0;
      cand_vld_q <= 1'b0;
    end else if (accept) begin
      cand_q     <= shift_q;
      cand_vld_q <= 1'b1;
    end else if (error) begin
      cand_vld_q <= 1'b0;
    end
  end
`else
  assign commit = accept;
`endif

  assign wr_clr = bus.BUS_WE && (bus.BUS_ADDR == IRRxBaseAddr + 8'd1);
  assign rd_hit = !bus.BUS_WE &&
                  ((bus.BUS_ADDR == IRRxBaseAddr) || (bus.BUS_ADDR == IRRxBaseAddr + 8'd1));

  // Event sets are applied after the write-clear and ACK so that they win on collision.
  always_comb begin
    cmd_d    = cmd_q;
    status_d = status_q;
    raise_d  = raise_q;
    if (wr_clr) status_d = '0;
    if (bus.BUS_INTERRUPT_ACK) raise_d = 1'b0;
    if (commit) begin
      cmd_d       = shift_q;
      status_d[0] = 1'b1;
      status_d[2] = status_q[2] | status_q[0];
      raise_d     = 1'b1;
    end
    if (error) status_d[1] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cmd_q     <= '0;
      status_q  <= '0;
      raise_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      cmd_q    <= cmd_d;
      status_q <= status_d;
      raise_q  <= raise_d;
      rd_en_q  <= rd_hit;
      if (rd_hit) begin
        rd_data_q <= (bus.BUS_ADDR == IRRxBaseAddr) ? {4'b0, cmd_q} : {5'b0, status_q};
      end
    end
  end

  assign BUS_DATA                = rd_en_q ? rd_data_q : 8'hzz;
  assign COMMAND_OUT             = cmd_q;
  assign bus.BUS_INTERRUPT_RAISE = raise_q;
  assign dbg_state_o             = state_q;
  assign dbg_bus_oe_o            = rd_en_q;
endmodule
